apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//   APB2 requester (master) driving the single-slave APB bus that the register-file slave sits on.
//   Converts a simple valid/ready command port from a local controller (CPU stub, DMA, test
//   sequencer) into compliant SETUP/ACCESS bus transfers, waits on PREADY and returns one response
//   per command. One transfer in flight at a time. A watchdog aborts a transfer if the slave stalls.
// PARAMETERS
//   DATA_WIDTH      32  width of PWDATA/PRDATA/cmd_wdata/rsp_rdata
//   ADDR_WIDTH      16  width of PADDR/cmd_addr
//   TIMEOUT_CYCLES  16  max ACCESS cycles waiting for PREADY; 0 = watchdog disabled (wait forever)
// PORTS
//   PCLK         in   1           bus clock; all logic on rising edge
//   PRESETn      in   1           asynchronous active-low reset
//   cmd_valid    in   1           command request
//   cmd_ready    out  1           master can accept a command (high only in IDLE)
//   cmd_write    in   1           1 = write, 0 = read
//   cmd_addr     in   ADDR_WIDTH  transfer address
//   cmd_wdata    in   DATA_WIDTH  write data (ignored for reads)
//   rsp_valid    out  1           one-cycle pulse: transfer finished
//   rsp_rdata    out  DATA_WIDTH  read data (0 for writes or timeout); valid with rsp_valid
//   rsp_timeout  out  1           transfer aborted by watchdog; valid with rsp_valid
//   PSELx        out  1           APB slave select
//   PENABLE      out  1           APB enable (second and later transfer cycles)
//   PADDR        out  ADDR_WIDTH  APB address
//   PWRITE       out  1           APB direction
//   PWDATA       out  DATA_WIDTH  APB write data
//   PREADY       in   1           slave ready / transfer complete
//   PRDATA       in   DATA_WIDTH  slave read data
// BEHAVIOUR
//   - Reset (PRESETn low, async): state IDLE; PSELx, PENABLE, PWRITE, rsp_valid, rsp_timeout = 0;
//     PADDR, PWDATA, rsp_rdata = 0; watchdog counter = 0. Reset mid-transfer drops it, no response.
//   - All outputs registered except cmd_ready = (state == IDLE).
//   - FSM states: IDLE, SETUP, ACCESS.
//     IDLE:   cmd_valid & cmd_ready at edge -> latch cmd_addr/cmd_write/cmd_wdata into PADDR/PWRITE/
//             PWDATA, PSELx<=1, PENABLE<=0, -> SETUP. Else stay; PSELx=PENABLE=0.
//     SETUP:  exactly one cycle; PENABLE<=1, counter<=0, -> ACCESS. PREADY ignored here.
//     ACCESS: PREADY sampled high -> PSELx<=0, PENABLE<=0, rsp_valid<=1, rsp_timeout<=0,
//             rsp_rdata<=PWRITE ? 0 : PRDATA; -> IDLE.
//             PREADY low -> counter+1; if TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES-1
//             -> abort: PSELx<=0, PENABLE<=0, rsp_valid<=1, rsp_timeout<=1, rsp_rdata<=0; -> IDLE.
//   - PREADY high and timeout on the same edge: PREADY wins (normal completion).
//   - PADDR/PWRITE/PWDATA stable from SETUP through end of ACCESS; hold last values while IDLE.
//   - rsp_valid high exactly one cycle; coincides with first IDLE cycle; no response backpressure.
//   - Minimum latency: accept edge -> SETUP (1) -> ACCESS (1) -> rsp_valid at 3rd edge with
//     PREADY already high in ACCESS. Back-to-back commands: cmd_ready high during the rsp_valid
//     cycle, so next SETUP starts 1 cycle after rsp_valid; PSELx deasserts for >=1 cycle between.
//   - Counter width $clog2(TIMEOUT_CYCLES+1), saturates; never wraps.
//   - cmd_* sampled only on the accept edge; changes at other times have no effect.
// TESTING
//   1 Write 0x0040 <= 0xDEADBEEF, PREADY high 3 cycles after PENABLE -> PSELx/PENABLE/PADDR
//     sequence correct, PWDATA stable all transfer, single rsp_valid, rsp_timeout=0, rsp_rdata=0.
//   2 Read 0x0040 after test 1, PRDATA=0xDEADBEEF with PREADY -> rsp_rdata=0xDEADBEEF on rsp_valid.
//   3 PREADY tied 0, TIMEOUT_CYCLES=16 -> abort after 16 ACCESS cycles, rsp_timeout=1,
//     rsp_rdata=0, PSELx=0 next cycle, cmd_ready=1.
//   4 cmd_valid held high for 4 writes to 0x0000/0x0080/0x0100/0x03c0 -> 4 responses in order,
//     PSELx low >=1 cycle between transfers, never PENABLE without prior SETUP cycle.
//   5 Assert PRESETn low during ACCESS of a read -> all outputs zero immediately, no rsp_valid,
//     after release next command completes normally.
//   6 PREADY rises on same edge the watchdog expires -> normal completion, rsp_timeout=0.

Source files
------------

// File: rtl/apb_master_bridge_if.sv
// Command/response port and APB bus bundle for the APB requester.
// The master modport is the bridge side; slave is the controller/bus side.
interface apb_master_bridge_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_timeout;
    logic                  PSELx;
    logic                  PENABLE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  PREADY, PRDATA,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
        output PSELx, PENABLE, PADDR, PWRITE, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output PREADY, PRDATA,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout,
        input  PSELx, PENABLE, PADDR, PWRITE, PWDATA
    );
endinterface

// File: rtl/apb_master_bridge.sv
// APB2 requester: turns one valid/ready command into a SETUP/ACCESS
// transfer, returns one response, and aborts stalled transfers.
module apb_master_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    apb_master_bridge_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    localparam int CW = (TIMEOUT_CYCLES > 0) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit WD_ON = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0] LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CW-1:0] SAT = '1;

    state_t        state;
    logic [CW-1:0] count;
    logic          expire;

    assign bus.cmd_ready = (state == IDLE);

    // Watchdog fires on the last permitted ACCESS cycle without PREADY.
    always_comb begin
        expire = WD_ON && (count == LAST);
    end

    // Transfer sequencing, bus outputs and the response pulse.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state           <= IDLE;
            count           <= '0;
            bus.PSELx       <= 1'b0;
            bus.PENABLE     <= 1'b0;
            bus.PWRITE      <= 1'b0;
            bus.PADDR       <= '0;
            bus.PWDATA      <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_timeout <= 1'b0;
            bus.rsp_rdata   <= '0;
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        bus.PADDR   <= bus.cmd_addr;
                        bus.PWRITE  <= bus.cmd_write;
                        bus.PWDATA  <= bus.cmd_wdata;
                        bus.PSELx   <= 1'b1;
                        bus.PENABLE <= 1'b0;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    bus.PENABLE <= 1'b1;
                    count       <= '0;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    if (bus.PREADY) begin
                        bus.PSELx       <= 1'b0;
                        bus.PENABLE     <= 1'b0;
                        bus.rsp_valid   <= 1'b1;
                        bus.rsp_timeout <= 1'b0;
                        bus.rsp_rdata   <= bus.PWRITE ? '0 : bus.PRDATA;
                        state           <= IDLE;
                    end else if (expire) begin
                        bus.PSELx       <= 1'b0;
                        bus.PENABLE     <= 1'b0;
                        bus.rsp_valid   <= 1'b1;
                        bus.rsp_timeout <= 1'b1;
                        bus.rsp_rdata   <= '0;
                        state           <= IDLE;
                    end else if (count != SAT) begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    bus.PSELx   <= 1'b0;
                    bus.PENABLE <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: vector table, hand-written
// corner sequences and randomized commands against a transaction model.
module tb_apb_master_bridge;
    localparam int TO = 16;

    logic PCLK;
    logic PRESETn;
    int   checks;
    int   errors;

    apb_master_bridge_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

    apb_master_bridge #(
        .DATA_WIDTH    (32),
        .ADDR_WIDTH    (16),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK   (PCLK),
        .PRESETn(PRESETn),
        .bus    (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Slave register file and the bench's own model of committed writes.
    logic [31:0] mem     [int];
    logic [31:0] ref_mem [int];

    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [31:0] d;
        int          waits;
        logic [31:0] rd;
        logic        to;
    } vec_t;

    vec_t vt [8];

    function automatic logic [31:0] rd_mem(input logic [15:0] a);
        return mem.exists(int'(a)) ? mem[int'(a)] : 32'h0;
    endfunction

    function automatic logic [31:0] rd_ref(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
    endfunction

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One command through the bus; slave raises PREADY after `waits`
    // low ACCESS cycles (never, if the watchdog expires first).
    task automatic run_cmd(input logic w, input logic [15:0] a,
                           input logic [31:0] d, input int waits,
                           input logic [31:0] exp_rd, input logic exp_to,
                           input string tag);
        int n;
        int bad;
        int exp_n;
        bit done;
        exp_n = exp_to ? TO : waits + 1;
        chk({tag, " ready"}, bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.PREADY    = 1'b0;
        step();
        bus.cmd_valid = 1'b0;
        bus.cmd_write = ~w;
        bus.cmd_addr  = ~a;
        bus.cmd_wdata = ~d;
        bus.PREADY    = 1'b1;
        bus.PRDATA    = $urandom;
        chk({tag, " setup"},
            {27'h0, bus.PSELx, bus.PENABLE, bus.cmd_ready,
             bus.rsp_valid, bus.PWRITE},
            {27'h0, 1'b1, 1'b0, 1'b0, 1'b0, w});
        chk({tag, " paddr"}, {16'h0, bus.PADDR}, {16'h0, a});
        chk({tag, " pwdata"}, bus.PWDATA, d);
        step();
        n = 0;
        bad = 0;
        done = 1'b0;
        while (!done && n < 64) begin
            if (!(bus.PSELx && bus.PENABLE && bus.PADDR == a &&
                  bus.PWRITE == w && bus.PWDATA == d && !bus.rsp_valid))
                bad++;
            bus.PREADY = (n == waits);
            bus.PRDATA = (bus.PREADY && !w) ? rd_mem(bus.PADDR) : $urandom;
            if (bus.PREADY && bus.PWRITE)
                mem[int'(bus.PADDR)] = bus.PWDATA;
            step();
            n++;
            done = bus.rsp_valid;
        end
        bus.PREADY = 1'b0;
        chk({tag, " access"}, bad, 0);
        chk({tag, " cycles"}, n, exp_n);
        chk({tag, " rsp"},
            {28'h0, bus.rsp_valid, bus.rsp_timeout, bus.PSELx,
             bus.cmd_ready},
            {28'h0, 1'b1, exp_to, 1'b0, 1'b1});
        chk({tag, " rdata"}, bus.rsp_rdata, exp_rd);
        step();
        chk({tag, " pulse"}, {30'h0, bus.rsp_valid, bus.PENABLE}, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " ctl"},
            {26'h0, bus.cmd_ready, bus.PSELx, bus.PENABLE, bus.PWRITE,
             bus.rsp_valid, bus.rsp_timeout},
            {26'h0, 6'b100000});
        chk({tag, " paddr"}, {16'h0, bus.PADDR}, 0);
        chk({tag, " pwdata"}, bus.PWDATA, 0);
        chk({tag, " rdata"}, bus.rsp_rdata, 0);
    endtask

    // Commands held valid back to back with PREADY tied high.
    task automatic burst();
        logic [15:0] ba [4];
        logic [31:0] bd [4];
        int idx;
        int nrsp;
        int viol;
        int cyc;
        bit acc;
        bit sel_b;
        ba = '{16'h0000, 16'h0080, 16'h0100, 16'h03c0};
        bd = '{32'h1111_0000, 32'h2222_0080, 32'h3333_0100, 32'h4444_03c0};
        idx = 0;
        nrsp = 0;
        viol = 0;
        cyc = 0;
        bus.PREADY    = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = ba[0];
        bus.cmd_wdata = bd[0];
        while (nrsp < 4 && cyc < 40) begin
            acc = bus.cmd_ready && bus.cmd_valid;
            if (bus.PSELx && bus.PENABLE && bus.PWRITE)
                mem[int'(bus.PADDR)] = bus.PWDATA;
            sel_b = bus.PSELx;
            step();
            cyc++;
            if (acc) begin
                idx++;
                if (idx < 4) begin
                    bus.cmd_addr  = ba[idx];
                    bus.cmd_wdata = bd[idx];
                end else begin
                    bus.cmd_valid = 1'b0;
                end
            end
            if (bus.PENABLE && !sel_b) viol++;
            if (bus.PSELx && !sel_b && bus.PENABLE) viol++;
            if (bus.rsp_valid && bus.PSELx) viol++;
            if (bus.rsp_valid) begin
                chk($sformatf("burst%0d resp", nrsp),
                    {bus.rsp_timeout, bus.rsp_rdata}, 33'h0);
                chk($sformatf("burst%0d order", nrsp),
                    {16'h0, bus.PADDR}, {16'h0, ba[nrsp]});
                ref_mem[int'(ba[nrsp])] = bd[nrsp];
                nrsp++;
            end
        end
        bus.PREADY    = 1'b0;
        bus.cmd_valid = 1'b0;
        chk("burst count", nrsp, 4);
        chk("burst proto", viol, 0);
        chk("burst cycles", cyc, 12);
        step();
    endtask

    // Reset asserted in the middle of a read's ACCESS phase.
    task automatic mid_reset();
        bit seen;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 16'h0040;
        bus.cmd_wdata = 32'h0;
        bus.PREADY    = 1'b0;
        step();
        bus.cmd_valid = 1'b0;
        step();
        chk("rst access", {30'h0, bus.PSELx, bus.PENABLE}, 3);
        step();
        step();
        #3;
        PRESETn = 1'b0;
        #1;
        chk_zero("rst async");
        bus.PREADY = 1'b1;
        bus.PRDATA = 32'hCAFE_F00D;
        seen = 1'b0;
        repeat (2) begin
            @(posedge PCLK);
            #1;
            if (bus.rsp_valid || bus.PSELx) seen = 1'b1;
        end
        chk("rst quiet", {31'h0, seen}, 0);
        bus.PREADY = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        step();
        chk("rst idle", {30'h0, bus.cmd_ready, bus.rsp_valid}, 2);
        run_cmd(1'b0, 16'h0040, 32'h0, 0, 32'hDEADBEEF, 1'b0, "rst after");
    endtask

    initial begin
        logic        w;
        logic [15:0] a;
        logic [31:0] d;
        logic [31:0] erd;
        logic        eto;
        int          wt;
        logic [15:0] aset [6];
        checks = 0;
        errors = 0;
        aset = '{16'h0000, 16'h0010, 16'h0020, 16'h0040, 16'h0080, 16'h03c0};

        vt[0] = '{1'b1, 16'h0040, 32'hDEADBEEF, 3,  32'h0,        1'b0};
        vt[1] = '{1'b0, 16'h0040, 32'h0,        0,  32'hDEADBEEF, 1'b0};
        vt[2] = '{1'b0, 16'h0010, 32'h0,        99, 32'h0,        1'b1};
        vt[3] = '{1'b1, 16'h0010, 32'h12345678, 15, 32'h0,        1'b0};
        vt[4] = '{1'b0, 16'h0010, 32'h0,        15, 32'h12345678, 1'b0};
        vt[5] = '{1'b1, 16'h0020, 32'hA5A5A5A5, 16, 32'h0,        1'b1};
        vt[6] = '{1'b0, 16'h0020, 32'h0,        1,  32'h0,        1'b0};
        vt[7] = '{1'b0, 16'h0040, 32'h0,        2,  32'hDEADBEEF, 1'b0};

        PRESETn       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.PREADY    = 1'b0;
        bus.PRDATA    = '0;
        repeat (2) step();
        chk_zero("reset");
        @(negedge PCLK);
        PRESETn = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            run_cmd(vt[i].w, vt[i].a, vt[i].d, vt[i].waits,
                    vt[i].rd, vt[i].to, $sformatf("vec%0d", i));
            if (vt[i].w && !vt[i].to) ref_mem[int'(vt[i].a)] = vt[i].d;
        end

        burst();
        mid_reset();

        for (int i = 0; i < 40; i++) begin
            w   = 1'($urandom_range(0, 1));
            a   = aset[$urandom_range(0, 5)];
            d   = $urandom;
            wt  = $urandom_range(0, 20);
            eto = (wt >= TO);
            erd = (!w && !eto) ? rd_ref(a) : 32'h0;
            repeat ($urandom_range(0, 2)) step();
            run_cmd(w, a, d, wt, erd, eto, $sformatf("rnd%0d", i));
            if (w && !eto) ref_mem[int'(a)] = d;
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
